// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Issues data-memory requests over a
// req/ready/rvld port, aligns store lanes, extends load data, flags
// misaligned accesses and stalls upstream while an access is pending.
// Holds the MEM/WB register; o_wb_data is also the EX forward source.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_vld .. i_nxt_pc     EX/MEM register contents
//   o_stall               hold EX/MEM and earlier stages
//   o_dmem_* / i_dmem_*   data-memory request/response port
//   o_vld .. o_nxt_pc     MEM/WB register
//   o_misalign, o_bus_err retire status
// Optional: define MEM_TIMEOUT_EN to abort loads that wait
// TIMEOUT_CYCLES in RESP (retire with o_bus_err=1).
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [2:0]  i_opsel,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvld,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_vld,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_misalign,
  output logic        o_bus_err
);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic        is_b, is_h, is_w;
  logic        is_bu, is_hu;
  logic        mem_acc;
  logic        misalign;
  logic        memop;
  logic        done;
  logic        bus_err;
  logic        timeout;
  logic [1:0]  a_lo;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  logic [31:0] st_data;
  logic [3:0]  st_mask;

  logic        vld_d, vld_q;
  logic [4:0]  rd_waddr_d, rd_waddr_q;
  logic        rd_wen_d, rd_wen_q;
  logic [31:0] wb_data_d, wb_data_q;
  logic [31:0] inst_d, inst_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] nxt_pc_d, nxt_pc_q;
  logic        misalign_d, misalign_q;
  logic        bus_err_d, bus_err_q;

  assign a_lo  = i_dmem_addr[1:0];
  assign is_b  = (i_opsel == 3'b000);
  assign is_h  = (i_opsel == 3'b001);
  assign is_w  = (i_opsel == 3'b010);
  assign is_bu = (i_opsel == 3'b100);
  assign is_hu = (i_opsel == 3'b101);

  assign mem_acc  = i_mem_read | i_mem_write;
  assign misalign = mem_acc &
                    (((is_h | is_hu) & a_lo[0]) |
                     (is_w & (a_lo != 2'b00)));
  assign memop    = i_vld & mem_acc & ~misalign;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_d, cnt_q;

  // Held at zero while idle, so it starts from zero on RESP entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE)
      cnt_d = 8'd0;
    else if (!i_dmem_rvld)
      cnt_d = cnt_q + 8'd1;
  end

  assign timeout = (state_q == S_RESP) & ~i_dmem_rvld &
                   (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    o_dmem_req = 1'b0;
    done       = 1'b0;
    bus_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_dmem_req = memop;
        if (memop && i_dmem_ready) begin
          if (i_mem_write) done = 1'b1;
          else state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_dmem_rvld) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          done    = 1'b1;
          bus_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_stall = memop & ~done;

  assign ld_b = 8'(i_dmem_rdata >> {a_lo, 3'b000});
  assign ld_h = a_lo[1] ? i_dmem_rdata[31:16]
                        : i_dmem_rdata[15:0];

  always_comb begin
    ld_ext = i_dmem_rdata;
    unique case (1'b1)
      is_b:    ld_ext = {{24{ld_b[7]}}, ld_b};
      is_h:    ld_ext = {{16{ld_h[15]}}, ld_h};
      is_bu:   ld_ext = {24'd0, ld_b};
      is_hu:   ld_ext = {16'd0, ld_h};
      default: ld_ext = i_dmem_rdata;
    endcase
  end

  always_comb begin
    st_data = i_dmem_wdata;
    st_mask = 4'h0;
    unique case (1'b1)
      is_b: begin
        st_data = {4{i_dmem_wdata[7:0]}};
        st_mask = 4'b0001 << a_lo;
      end
      is_h: begin
        st_data = {2{i_dmem_wdata[15:0]}};
        st_mask = 4'b0011 << {a_lo[1], 1'b0};
      end
      is_w: begin
        st_data = i_dmem_wdata;
        st_mask = 4'hF;
      end
      default: begin
        st_data = i_dmem_wdata;
        st_mask = 4'h0;
      end
    endcase
  end

  assign o_dmem_we    = i_mem_write;
  assign o_dmem_addr  = {i_dmem_addr[31:2], 2'b00};
  assign o_dmem_wdata = st_data;
  assign o_dmem_mask  = i_mem_write ? st_mask : 4'h0;

  always_comb begin
    vld_d      = i_vld & ~o_stall;
    rd_waddr_d = i_rd_waddr;
    rd_wen_d   = i_rd_wen & i_vld & ~o_stall &
                 ~misalign & ~bus_err;
    wb_data_d  = i_mem_reg ? ld_ext : i_res;
    inst_d     = i_inst;
    pc_d       = i_pc;
    nxt_pc_d   = i_nxt_pc;
    misalign_d = i_vld & ~o_stall & misalign;
    bus_err_d  = bus_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      vld_q      <= 1'b0;
      rd_waddr_q <= 5'd0;
      rd_wen_q   <= 1'b0;
      wb_data_q  <= 32'd0;
      inst_q     <= 32'd0;
      pc_q       <= 32'd0;
      nxt_pc_q   <= 32'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      rd_waddr_q <= rd_waddr_d;
      rd_wen_q   <= rd_wen_d;
      wb_data_q  <= wb_data_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      nxt_pc_q   <= nxt_pc_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign o_vld      = vld_q;
  assign o_rd_waddr = rd_waddr_q;
  assign o_rd_wen   = rd_wen_q;
  assign o_wb_data  = wb_data_q;
  assign o_inst     = inst_q;
  assign o_pc       = pc_q;
  assign o_nxt_pc   = nxt_pc_q;
  assign o_misalign = misalign_q;
  assign o_bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed + random checks of mem_stage against a
// transaction-level model of retire value, latency and bus lanes.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_vld;
  logic [31:0] i_res;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic [2:0]  i_opsel;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_mem_reg;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_nxt_pc;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready;
  logic        i_dmem_rvld;
  logic [31:0] i_dmem_rdata;
  logic        o_vld;
  logic [4:0]  o_rd_waddr;
  logic        o_rd_wen;
  logic [31:0] o_wb_data;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic [31:0] o_nxt_pc;
  logic        o_misalign;
  logic        o_bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld),
    .i_res(i_res), .i_dmem_addr(i_dmem_addr),
    .i_dmem_wdata(i_dmem_wdata), .i_opsel(i_opsel),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_mem_reg(i_mem_reg), .i_rd_waddr(i_rd_waddr),
    .i_rd_wen(i_rd_wen), .i_inst(i_inst), .i_pc(i_pc),
    .i_nxt_pc(i_nxt_pc), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_mask(o_dmem_mask), .i_dmem_ready(i_dmem_ready),
    .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata),
    .o_vld(o_vld), .o_rd_waddr(o_rd_waddr),
    .o_rd_wen(o_rd_wen), .o_wb_data(o_wb_data),
    .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
    .o_misalign(o_misalign), .o_bus_err(o_bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(
      input logic [2:0] op, input logic [31:0] a,
      input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> ((a & 2) * 8)) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // kind: 0 ALU, 1 load, 2 store. r = ready-low cycles,
  // d = response delay after acceptance, to = no response.
  task automatic run_op(input bit vld, input int kind,
                        input logic [2:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input logic [31:0] res,
                        input logic [4:0] rd, input bit wen,
                        input int r, input int d,
                        input logic [31:0] rdata,
                        input bit to);
    bit ld, st, mis, memop;
    int lat;
    logic [31:0] inst, pc, npc, exp_wd;
    logic [3:0] exp_m;
    ld  = (kind == 1);
    st  = (kind == 2);
    mis = (ld || st) &&
          (((op == 1 || op == 5) && addr % 2 != 0) ||
           (op == 2 && addr % 4 != 0));
    memop = vld && (ld || st) && !mis;
    lat = !memop ? 0 : (st ? r : r + d);
    case (op)
      3'd0: begin
        exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        exp_m  = 4'(1 << (addr % 4));
      end
      3'd1: begin
        exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        exp_m  = 4'(3 << (addr & 2));
      end
      default: begin
        exp_wd = wd;
        exp_m  = 4'hF;
      end
    endcase
    inst = $urandom; pc = $urandom; npc = pc + 4;
    i_vld = vld; i_mem_read = ld; i_mem_write = st;
    i_mem_reg = ld; i_opsel = op; i_dmem_addr = addr;
    i_dmem_wdata = wd; i_res = res; i_rd_waddr = rd;
    i_rd_wen = wen; i_inst = inst; i_pc = pc;
    i_nxt_pc = npc;
    for (int k = 0; k <= lat; k++) begin
      if (k < r)       i_dmem_ready = 1'b0;
      else if (k == r) i_dmem_ready = 1'b1;
      else             i_dmem_ready = 1'($urandom % 2);
      if (!memop || k < r)
        i_dmem_rvld = 1'($urandom % 2);
      else
        i_dmem_rvld = ld && !to && (k == r + d);
      i_dmem_rdata = (k == r + d) ? rdata : $urandom;
      #1;
      chk("stall", o_stall, k < lat);
      chk("req", o_dmem_req, memop && k <= r);
      if (memop && k <= r) begin
        chk("addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
        chk("we", o_dmem_we, st);
        chk("mask", o_dmem_mask, st ? exp_m : 4'h0);
        if (st) chk("wdata", o_dmem_wdata, exp_wd);
      end
      @(negedge i_clk);
    end
    chk("o_vld", o_vld, vld);
    chk("o_rd_wen", o_rd_wen, vld && wen && !mis && !to);
    chk("o_misalign", o_misalign, vld && mis);
    chk("o_bus_err", o_bus_err, memop && to);
    if (vld) begin
      chk("o_rd_waddr", o_rd_waddr, rd);
      chk("o_inst", o_inst, inst);
      chk("o_pc", o_pc, pc);
      chk("o_nxt_pc", o_nxt_pc, npc);
      if (!mis && !to)
        chk("o_wb_data", o_wb_data,
            ld ? ref_load(op, addr, rdata) : res);
    end
  endtask

  initial begin
    int kind, r, d;
    logic [2:0] op;
    logic [31:0] a;
    logic [2:0] ld_ops [5];
`ifdef MEM_TIMEOUT_EN
    int lhu_d = 4;
`else
    int lhu_d = 5;
`endif
    ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    i_rst = 1'b1; i_vld = 0; i_res = 0; i_dmem_addr = 0;
    i_dmem_wdata = 0; i_opsel = 0; i_mem_read = 0;
    i_mem_write = 0; i_mem_reg = 0; i_rd_waddr = 0;
    i_rd_wen = 0; i_inst = 0; i_pc = 0; i_nxt_pc = 0;
    i_dmem_ready = 0; i_dmem_rvld = 0; i_dmem_rdata = 0;
    repeat (2) @(negedge i_clk);
    chk("rst_vld", o_vld, 0);
    chk("rst_wen", o_rd_wen, 0);
    chk("rst_wb", o_wb_data, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_dmem_req, 0);
    i_rst = 1'b0;

    run_op(1, 0, 3'd0, 32'h0, 0, 32'h1234, 5, 1, 0, 1, 0, 0);
    run_op(1, 1, 3'd0, 32'h1003, 0, 0, 6, 1, 0, 1,
           32'h80FF_FFFF, 0);
    run_op(1, 2, 3'd1, 32'h2002, 32'h1234_BEEF, 0, 0, 0,
           3, 1, 0, 0);
    run_op(1, 1, 3'd2, 32'h3001, 0, 0, 7, 1, 0, 1, 0, 0);
    run_op(1, 1, 3'd5, 32'h4002, 0, 0, 8, 1, 0, lhu_d,
           32'h9ABC_0000, 0);
    run_op(1, 2, 3'd0, 32'h2003, 32'h55, 0, 0, 0,
           0, 1, 0, 0);
    run_op(0, 1, 3'd2, 32'h5000, 0, 0, 9, 1, 0, 1, 0, 0);
`ifdef MEM_TIMEOUT_EN
    run_op(1, 1, 3'd2, 32'h6000, 0, 0, 10, 1, 1, 4, 0, 1);
`endif

    // Reset while waiting in RESP: access is dropped.
    i_vld = 1; i_mem_read = 1; i_mem_write = 0;
    i_mem_reg = 1; i_opsel = 3'd2; i_dmem_addr = 32'h7000;
    i_rd_wen = 1; i_dmem_ready = 1; i_dmem_rvld = 0;
    #1;
    chk("rr_issue", o_dmem_req, 1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0; i_vld = 0; i_mem_read = 0;
    i_dmem_rvld = 1; i_dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rr_vld", o_vld, 0);
    chk("rr_stall", o_stall, 0);
    chk("rr_req", o_dmem_req, 0);
    @(negedge i_clk);
    i_dmem_rvld = 0;
    chk("rr_late", o_vld, 0);
    chk("rr_late_wen", o_rd_wen, 0);
    run_op(1, 1, 3'd1, 32'h7002, 0, 0, 11, 1, 1, 2,
           32'h8001_0000, 0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 2) op = 3'($urandom_range(0, 2));
      else if (kind == 1) op = ld_ops[$urandom_range(0, 4)];
      else op = 3'($urandom);
      a = $urandom;
      if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
      r = $urandom_range(0, 3);
      d = $urandom_range(1, 4);
      run_op(($urandom % 10) != 0, kind, op, a, $urandom,
             $urandom, 5'($urandom), 1'($urandom % 2),
             r, d, $urandom, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
